// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and defaults for the register-file writeback
//               arbiter and its pending-register scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

   // Register index width for the default 8-entry register file
   localparam int REGW = 3;

   // Consecutive lost cycles before the pipeline is held for a side requester
   localparam int STARVE_MAX_DEFAULT = 4;

   // Which source owns the register-file write port in a given cycle
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_PIPE = 2'd1,
      SRC_MEM  = 2'd2,
      SRC_FFT  = 2'd3
   } wb_src_t;

   typedef logic [REGW-1:0] reg_idx_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : wb_scoreboard
// Description : Per-register pending bits for outstanding long-latency ops
//               (loads, FFT results) and the decode stall compare.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_scoreboard #(
   parameter int NUMREGISTERS = 8,
   parameter int REGW         = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    issue_en,
   input  logic [REGW-1:0]         issue_reg,
   input  logic                    clr_en,
   input  logic [REGW-1:0]         clr_reg,
   input  logic [REGW-1:0]         rd_reg1,
   input  logic [REGW-1:0]         rd_reg2,
   output logic [NUMREGISTERS-1:0] pending,
   output logic                    stall
);

   logic [NUMREGISTERS-1:0] set_mask;
   logic [NUMREGISTERS-1:0] clr_mask;

   // One-hot set/clear masks for this edge
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (issue_en) set_mask[issue_reg] = 1'b1;
      if (clr_en)   clr_mask[clr_reg]   = 1'b1;
   end

   // Pending vector: clear first, then set, so a same-edge issue survives
   always_ff @(posedge clk) begin
      if (rst) pending <= '0;
      else     pending <= (pending & ~clr_mask) | set_mask;
   end

   // RAW on either source, or WAW of a new long op against an outstanding one
   always_comb begin
      stall = 1'b0;
      if (!rst)
         stall = pending[rd_reg1] | pending[rd_reg2] | (issue_en & pending[issue_reg]);
   end

endmodule : wb_scoreboard
`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_arbiter
// Description : Owns the single register-file write port. The pipeline
//               writeback always wins; loads and FFT results share the
//               remaining cycles round-robin on ties, with a starvation
//               counter that holds the pipeline for one cycle when needed.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_wb_arbiter
   import wb_pkg::*;
#(
   parameter int NUMREGISTERS = 8,
   parameter int REGW         = 3,
   parameter int DATAW        = 32,
   parameter int STARVE_MAX   = STARVE_MAX_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pipe_wr_en,
   input  logic [REGW-1:0]         pipe_wr_reg,
   input  logic [DATAW-1:0]        pipe_wr_data,
   input  logic                    mem_vld,
   input  logic [REGW-1:0]         mem_reg,
   input  logic [DATAW-1:0]        mem_data,
   output logic                    mem_rdy,
   input  logic                    fft_vld,
   input  logic [REGW-1:0]         fft_reg,
   input  logic [DATAW-1:0]        fft_data,
   output logic                    fft_rdy,
   input  logic                    issue_en,
   input  logic [REGW-1:0]         issue_reg,
   input  logic [REGW-1:0]         rd_reg1,
   input  logic [REGW-1:0]         rd_reg2,
   output logic                    stall,
   output logic                    pipe_hold,
   output logic                    wr_reg_en,
   output logic [REGW-1:0]         wr_reg,
   output logic [DATAW-1:0]        wr_data,
   output logic [NUMREGISTERS-1:0] pending
);

   localparam int CNTW = $clog2(STARVE_MAX + 1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(STARVE_MAX - 1);
   localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(STARVE_MAX);

   wb_src_t         grant;
   wb_src_t         last_grant;
   logic            tie;
   logic            side_any;
   logic            side_acc;
   logic [REGW-1:0] acc_reg;
   logic [CNTW-1:0] starve_cnt;

   // Pick this cycle's write-port owner
   always_comb begin
      grant = SRC_NONE;
      tie   = mem_vld & fft_vld;
      if (rst)             grant = SRC_NONE;
      else if (pipe_wr_en) grant = SRC_PIPE;
      else if (tie)        grant = (last_grant == SRC_FFT) ? SRC_MEM : SRC_FFT;
      else if (mem_vld)    grant = SRC_MEM;
      else if (fft_vld)    grant = SRC_FFT;
   end

   assign mem_rdy  = (grant == SRC_MEM);
   assign fft_rdy  = (grant == SRC_FFT);
   assign side_any = mem_vld | fft_vld;
   assign side_acc = mem_rdy | fft_rdy;
   assign acc_reg  = mem_rdy ? mem_reg : fft_reg;

   // Registered write port; index/data hold when nobody writes
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_reg_en <= 1'b0;
         wr_reg    <= '0;
         wr_data   <= '0;
      end else begin
         wr_reg_en <= (grant != SRC_NONE);
         case (grant)
            SRC_PIPE: begin wr_reg <= pipe_wr_reg; wr_data <= pipe_wr_data; end
            SRC_MEM:  begin wr_reg <= mem_reg;     wr_data <= mem_data;     end
            SRC_FFT:  begin wr_reg <= fft_reg;     wr_data <= fft_data;     end
            default:  ;
         endcase
      end
   end

   // Round-robin memory: only a contested grant moves the pointer
   always_ff @(posedge clk) begin
      if (rst)
         last_grant <= SRC_FFT;
      else if (tie && side_acc)
         last_grant <= grant;
   end

   // Starvation counter and one-cycle pipeline hold
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
         pipe_hold  <= 1'b0;
      end else begin
         pipe_hold <= 1'b0;
         if (side_acc || !side_any) begin
            starve_cnt <= '0;
         end else if (pipe_wr_en) begin
            if (starve_cnt == CNT_LAST) begin
               pipe_hold  <= 1'b1;
               starve_cnt <= '0;
            end else if (starve_cnt < CNT_SAT) begin
               starve_cnt <= starve_cnt + 1'b1;
            end
         end
      end
   end

   // The pipeline must honour pipe_hold; it still wins if it does not
   always_ff @(posedge clk) begin
      if (!rst) assert (!(pipe_hold && pipe_wr_en));
   end

   wb_scoreboard #(
      .NUMREGISTERS (NUMREGISTERS),
      .REGW         (REGW)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .issue_en  (issue_en),
      .issue_reg (issue_reg),
      .clr_en    (side_acc),
      .clr_reg   (acc_reg),
      .rd_reg1   (rd_reg1),
      .rd_reg2   (rd_reg2),
      .pending   (pending),
      .stall     (stall)
   );

endmodule : reg_wb_arbiter
`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_wb_arbiter
// Description : Self-checking bench for reg_wb_arbiter: directed scenarios
//               followed by random traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_wb_arbiter;

   localparam int W_NONE = 0;
   localparam int W_PIPE = 1;
   localparam int W_MEM  = 2;
   localparam int W_FFT  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pipe_wr_en = 1'b0;
   logic [2:0]  pipe_wr_reg = '0;
   logic [31:0] pipe_wr_data = '0;
   logic        mem_vld = 1'b0;
   logic [2:0]  mem_reg = '0;
   logic [31:0] mem_data = '0;
   logic        mem_rdy;
   logic        fft_vld = 1'b0;
   logic [2:0]  fft_reg = '0;
   logic [31:0] fft_data = '0;
   logic        fft_rdy;
   logic        issue_en = 1'b0;
   logic [2:0]  issue_reg = '0;
   logic [2:0]  rd_reg1 = '0;
   logic [2:0]  rd_reg2 = '0;
   logic        stall;
   logic        pipe_hold;
   logic        wr_reg_en;
   logic [2:0]  wr_reg;
   logic [31:0] wr_data;
   logic [7:0]  pending;

   int tests = 0;
   int fails = 0;

   // Reference model state
   bit          m_pend [8];
   bit          m_last_fft = 1'b1;
   int          m_starve = 0;
   bit          m_hold = 1'b0;
   bit          m_wr_en = 1'b0;
   logic [2:0]  m_wr_reg = '0;
   logic [31:0] m_wr_data = '0;
   int          last_win = W_NONE;

   // Snapshots of the combinational outputs from the latest step
   logic obs_mem_rdy, obs_fft_rdy, obs_stall;

   always #5 clk = ~clk;

   reg_wb_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .pipe_wr_en   (pipe_wr_en),
      .pipe_wr_reg  (pipe_wr_reg),
      .pipe_wr_data (pipe_wr_data),
      .mem_vld      (mem_vld),
      .mem_reg      (mem_reg),
      .mem_data     (mem_data),
      .mem_rdy      (mem_rdy),
      .fft_vld      (fft_vld),
      .fft_reg      (fft_reg),
      .fft_data     (fft_data),
      .fft_rdy      (fft_rdy),
      .issue_en     (issue_en),
      .issue_reg    (issue_reg),
      .rd_reg1      (rd_reg1),
      .rd_reg2      (rd_reg2),
      .stall        (stall),
      .pipe_hold    (pipe_hold),
      .wr_reg_en    (wr_reg_en),
      .wr_reg       (wr_reg),
      .wr_data      (wr_data),
      .pending      (pending)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_pending();
      logic [7:0] v = '0;
      for (int i = 0; i < 8; i++) v[i] = m_pend[i];
      return v;
   endfunction

   // Who should own the write port given current inputs and model state
   function automatic int model_winner();
      if (rst)                return W_NONE;
      if (pipe_wr_en)         return W_PIPE;
      if (mem_vld && fft_vld) return m_last_fft ? W_MEM : W_FFT;
      if (mem_vld)            return W_MEM;
      if (fft_vld)            return W_FFT;
      return W_NONE;
   endfunction

   // One clock: check combinational outputs, advance the model, check registers
   task automatic step();
      int  win;
      bit  exp_stall;
      #1;
      win = model_winner();
      exp_stall = !rst && (m_pend[rd_reg1] || m_pend[rd_reg2] || (issue_en && m_pend[issue_reg]));
      chk("mem_rdy", 32'(mem_rdy), 32'(win == W_MEM));
      chk("fft_rdy", 32'(fft_rdy), 32'(win == W_FFT));
      chk("stall",   32'(stall),   32'(exp_stall));
      obs_mem_rdy = mem_rdy;
      obs_fft_rdy = fft_rdy;
      obs_stall   = stall;
      @(posedge clk);
      last_win = win;
      if (rst) begin
         for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
         m_last_fft = 1'b1;
         m_starve   = 0;
         m_hold     = 1'b0;
         m_wr_en    = 1'b0;
         m_wr_reg   = '0;
         m_wr_data  = '0;
      end else begin
         m_wr_en = (win != W_NONE);
         if (win == W_PIPE) begin m_wr_reg = pipe_wr_reg; m_wr_data = pipe_wr_data; end
         if (win == W_MEM)  begin m_wr_reg = mem_reg;     m_wr_data = mem_data;     end
         if (win == W_FFT)  begin m_wr_reg = fft_reg;     m_wr_data = fft_data;     end
         if (mem_vld && fft_vld && (win == W_MEM || win == W_FFT)) m_last_fft = (win == W_FFT);
         if (win == W_MEM) m_pend[mem_reg] = 1'b0;
         if (win == W_FFT) m_pend[fft_reg] = 1'b0;
         if (issue_en)     m_pend[issue_reg] = 1'b1;
         m_hold = 1'b0;
         if (win == W_MEM || win == W_FFT || !(mem_vld || fft_vld)) begin
            m_starve = 0;
         end else if (pipe_wr_en) begin
            if (m_starve == 3) begin m_hold = 1'b1; m_starve = 0; end
            else               m_starve = m_starve + 1;
         end
      end
      #1;
      chk("wr_reg_en", 32'(wr_reg_en), 32'(m_wr_en));
      chk("wr_reg",    32'(wr_reg),    32'(m_wr_reg));
      chk("wr_data",   wr_data,        m_wr_data);
      chk("pending",   32'(pending),   32'(model_pending()));
      chk("pipe_hold", 32'(pipe_hold), 32'(m_hold));
   endtask

   initial begin
      logic [3:0] seq;

      // Reset
      rst = 1'b1;
      step();
      step();
      chk("reset_pending", 32'(pending), 32'h0);
      chk("reset_wr_en",   32'(wr_reg_en), 32'h0);
      rst = 1'b0;

      // Single load return
      mem_vld = 1'b1; mem_reg = 3'd3; mem_data = 32'hDEADBEEF;
      step();
      chk("single_mem_rdy", 32'(obs_mem_rdy), 32'h1);
      chk("single_wr_reg",  32'(wr_reg), 32'h3);
      chk("single_wr_data", wr_data, 32'hDEADBEEF);
      mem_vld = 1'b0;

      // Tie between mem and fft alternates starting with mem
      mem_vld = 1'b1; mem_reg = 3'd1; mem_data = 32'h1111_0001;
      fft_vld = 1'b1; fft_reg = 3'd2; fft_data = 32'h2222_0002;
      for (int i = 0; i < 4; i++) begin
         step();
         seq[i] = obs_mem_rdy;
         chk("tie_wr_en", 32'(wr_reg_en), 32'h1);
      end
      chk("tie_order", 32'(seq), 32'h5);
      mem_vld = 1'b0; fft_vld = 1'b0;

      // Starvation: pipeline writes every cycle while a load waits
      mem_vld = 1'b1; mem_reg = 3'd4; mem_data = 32'hCAFE_0004;
      pipe_wr_en = 1'b1; pipe_wr_reg = 3'd7; pipe_wr_data = 32'h7777_7777;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("starve_mem_rdy", 32'(obs_mem_rdy), 32'h0);
      end
      chk("starve_hold", 32'(pipe_hold), 32'h1);
      pipe_wr_en = 1'b0;
      step();
      chk("hold_mem_rdy", 32'(obs_mem_rdy), 32'h1);
      chk("hold_cleared", 32'(pipe_hold), 32'h0);
      mem_vld = 1'b0;
      step();

      // RAW stall until the FFT result for reg 5 lands
      issue_en = 1'b1; issue_reg = 3'd5;
      step();
      issue_en = 1'b0; rd_reg1 = 3'd5;
      step();
      chk("raw_stall", 32'(obs_stall), 32'h1);
      step();
      fft_vld = 1'b1; fft_reg = 3'd5; fft_data = 32'h5555_AAAA;
      step();
      chk("raw_stall_accept", 32'(obs_stall), 32'h1);
      chk("raw_write_reg5", 32'(wr_reg), 32'h5);
      chk("raw_stall_clear", 32'(stall), 32'h0);
      fft_vld = 1'b0;
      step();
      rd_reg1 = 3'd0;

      // Same-edge issue and acceptance of reg 2: set wins
      issue_en = 1'b1; issue_reg = 3'd2;
      mem_vld = 1'b1; mem_reg = 3'd2; mem_data = 32'h0000_0222;
      step();
      chk("setwins_pending2", 32'(pending[2]), 32'h1);
      issue_en = 1'b0; mem_vld = 1'b0; rd_reg2 = 3'd2;
      step();
      chk("setwins_stall", 32'(obs_stall), 32'h1);
      rd_reg2 = 3'd0;

      // Reset mid-operation with pending = 0x24 and a load in flight
      issue_en = 1'b1; issue_reg = 3'd5;
      step();
      issue_en = 1'b0;
      chk("pre_reset_pending", 32'(pending), 32'h24);
      mem_vld = 1'b1; mem_reg = 3'd6; mem_data = 32'h6666_6666;
      rst = 1'b1;
      step();
      chk("midreset_pending", 32'(pending), 32'h0);
      chk("midreset_wr_en",   32'(wr_reg_en), 32'h0);
      chk("midreset_hold",    32'(pipe_hold), 32'h0);
      rst = 1'b0; mem_vld = 1'b0;
      step();

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         if (!(mem_vld && last_win != W_MEM)) begin
            mem_vld  = ($urandom_range(0, 2) == 0);
            mem_reg  = 3'($urandom);
            mem_data = $urandom;
         end
         if (!(fft_vld && last_win != W_FFT)) begin
            fft_vld  = ($urandom_range(0, 2) == 0);
            fft_reg  = 3'($urandom);
            fft_data = $urandom;
         end
         pipe_wr_en   = m_hold ? 1'b0 : ($urandom_range(0, 1) == 1);
         pipe_wr_reg  = 3'($urandom);
         pipe_wr_data = $urandom;
         issue_en     = ($urandom_range(0, 3) == 0);
         issue_reg    = 3'($urandom);
         rd_reg1      = 3'($urandom);
         rd_reg2      = 3'($urandom);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_reg_wb_arbiter
`default_nettype wire
